fetch_unit: RTL and testbench

//   F stage of the P7 five-stage MIPS pipeline: PC register, next-PC selection and the F/D pipeline register.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_fd_reg.sv | 71 +++++++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared MIPS pipeline definitions: exception codes, fetch address map and
// the fetch-address legality helper used by the F stage.
package mips_defs;

    localparam logic [4:0]  EXC_NONE  = 5'd0;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_TOP    = 32'h0000_6ffc;

    // True when a fetch address is misaligned or outside instruction memory.
    function automatic logic fetch_addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IM_BASE) || (addr > IM_TOP);
    endfunction

endpackage

// File: rtl/fetch_unit_fd_reg.sv
// F/D pipeline register. Flush beats stall and loads a bubble (nop, no
// exception, no delay-slot flag) at the supplied bubble PC; stall holds.
// The same shape is intended for the later stage registers.
module fd_reg
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] bubble_pc,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [4:0]  exc_in,
    input  logic        bd_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [4:0]  exc,
    output logic        bd
);

    logic [31:0] instr_d, instr_q;
    logic [31:0] pc_d,    pc_q;
    logic [4:0]  exc_d,   exc_q;
    logic        bd_d,    bd_q;

    // Select flush bubble, hold, or load of the fetched slot.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        if (flush) begin
            instr_d = 32'h0000_0000;
            pc_d    = bubble_pc;
            exc_d   = EXC_NONE;
            bd_d    = 1'b0;
        end else if (stall) begin
            instr_d = instr_q;
            pc_d    = pc_q;
            exc_d   = exc_q;
            bd_d    = bd_q;
        end else begin
            instr_d = instr_in;
            pc_d    = pc_in;
            exc_d   = exc_in;
            bd_d    = bd_in;
        end
    end

    // Register the D-stage fields; reset gives an empty slot at the reset PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= 32'h0000_0000;
            pc_q    <= PC_RESET;
            exc_q   <= EXC_NONE;
            bd_q    <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign exc   = exc_q;
    assign bd    = bd_q;

endmodule

// File: rtl/fetch_unit.sv
// F stage of the five-stage MIPS pipeline: PC register, next-PC selection,
// fetch address-error detection and the F/D register.
// Optional feature macro: ADEL_CHECK_EN enables fetch AdEL detection; when
// undefined the fetch exception code is always zero and the memory word is
// passed through for any PC.
module fetch_unit
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        F_Stall,
    input  logic        D_IsBranch,
    input  logic        D_BranchTaken,
    input  logic [31:0] D_BranchTarget,
    input  logic        D_Eret,
    input  logic [31:0] EPC,
    input  logic        Req,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] D_Instr,
    output logic [31:0] D_PC,
    output logic [4:0]  D_ExcCode,
    output logic        D_BD
);

    logic [31:0] f_pc_d, f_pc_q;
    logic [4:0]  f_exc;
    logic [31:0] f_instr;
    logic        fd_flush;
    logic [31:0] fd_bubble_pc;

    // Next-PC priority: exception entry, stall hold, eret, branch, sequential.
    always_comb begin
        f_pc_d = f_pc_q;
        if (Req) begin
            f_pc_d = EXC_ENTRY;
        end else if (F_Stall) begin
            f_pc_d = f_pc_q;
        end else if (D_Eret) begin
            f_pc_d = EPC;
        end else if (D_BranchTaken) begin
            f_pc_d = D_BranchTarget;
        end else begin
            f_pc_d = f_pc_q + 32'd4;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q <= PC_RESET;
        end else begin
            f_pc_q <= f_pc_d;
        end
    end

    // Fetch exception code and the word handed to D (nop on a bad fetch).
    always_comb begin
`ifdef ADEL_CHECK_EN
        if (fetch_addr_bad(f_pc_q)) begin
            f_exc = EXC_ADEL;
        end else begin
            f_exc = EXC_NONE;
        end
`else
        f_exc = EXC_NONE;
`endif
        if (f_exc != EXC_NONE) begin
            f_instr = 32'h0000_0000;
        end else begin
            f_instr = i_inst_rdata;
        end
    end

    // Req flushes even a stalled slot; eret flushes only once the stall clears
    // so a stalled eret keeps its slot and redirect pending.
    always_comb begin
        fd_flush = Req | (D_Eret & ~F_Stall);
        if (Req) begin
            fd_bubble_pc = EXC_ENTRY;
        end else begin
            fd_bubble_pc = EPC;
        end
    end

    fd_reg u_fd_reg (
        .clk       (clk),
        .reset     (reset),
        .stall     (F_Stall),
        .flush     (fd_flush),
        .bubble_pc (fd_bubble_pc),
        .instr_in  (f_instr),
        .pc_in     (f_pc_q),
        .exc_in    (f_exc),
        .bd_in     (D_IsBranch),
        .instr     (D_Instr),
        .pc        (D_PC),
        .exc       (D_ExcCode),
        .bd        (D_BD)
    );

    assign i_inst_addr = f_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// control traffic, all compared against a behavioural model of the F stage.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] T_PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] T_EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] T_IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] T_IM_TOP    = 32'h0000_6ffc;

    logic        clk = 1'b0;
    logic        reset, F_Stall, D_IsBranch, D_BranchTaken, D_Eret, Req;
    logic [31:0] D_BranchTarget, EPC, i_inst_rdata, i_inst_addr;
    logic [31:0] D_Instr, D_PC;
    logic [4:0]  D_ExcCode;
    logic        D_BD;

    int checks   = 0;
    int failures = 0;

    // Reference state of the F stage.
    logic [31:0] m_pc, m_instr, m_dpc;
    logic [4:0]  m_exc;
    logic        m_bd;

    always #5 clk = ~clk;

    // Instruction memory contents: a scrambled function of the address.
    function automatic logic [31:0] im_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign i_inst_rdata = im_word(i_inst_addr);

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .F_Stall        (F_Stall),
        .D_IsBranch     (D_IsBranch),
        .D_BranchTaken  (D_BranchTaken),
        .D_BranchTarget (D_BranchTarget),
        .D_Eret         (D_Eret),
        .EPC            (EPC),
        .Req            (Req),
        .i_inst_rdata   (i_inst_rdata),
        .i_inst_addr    (i_inst_addr),
        .D_Instr        (D_Instr),
        .D_PC           (D_PC),
        .D_ExcCode      (D_ExcCode),
        .D_BD           (D_BD)
    );

    function automatic logic bad_fetch(input logic [31:0] a);
`ifdef ADEL_CHECK_EN
        return (a % 32'd4 != 32'd0) || (a < T_IM_BASE) || (a > T_IM_TOP);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock according to the current inputs.
    task automatic model_step();
        logic [31:0] nxt;
        if (reset) begin
            m_pc = T_PC_RESET; m_instr = 32'd0; m_dpc = T_PC_RESET; m_exc = 5'd0; m_bd = 1'b0;
            return;
        end
        if (Req) begin
            m_instr = 32'd0; m_dpc = T_EXC_ENTRY; m_exc = 5'd0; m_bd = 1'b0;
            nxt = T_EXC_ENTRY;
        end else if (F_Stall) begin
            nxt = m_pc;
        end else if (D_Eret) begin
            m_instr = 32'd0; m_dpc = EPC; m_exc = 5'd0; m_bd = 1'b0;
            nxt = EPC;
        end else begin
            m_instr = bad_fetch(m_pc) ? 32'd0 : im_word(m_pc);
            m_exc   = bad_fetch(m_pc) ? 5'd4 : 5'd0;
            m_dpc   = m_pc;
            m_bd    = D_IsBranch;
            nxt     = D_BranchTaken ? D_BranchTarget : m_pc + 32'd4;
        end
        m_pc = nxt;
    endtask

    // One clock: update model, wait for the edge, compare every output.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("i_inst_addr", i_inst_addr, m_pc);
        chk("D_Instr", D_Instr, m_instr);
        chk("D_PC", D_PC, m_dpc);
        chk("D_ExcCode", {27'd0, D_ExcCode}, {27'd0, m_exc});
        chk("D_BD", {31'd0, D_BD}, {31'd0, m_bd});
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 1'b0; F_Stall = 1'b0; D_IsBranch = 1'b0; D_BranchTaken = 1'b0;
        D_BranchTarget = 32'd0; D_Eret = 1'b0; EPC = 32'd0; Req = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0:       a = T_IM_BASE;
            1:       a = T_IM_TOP;
            2:       a = T_IM_TOP + 32'd4;
            3:       a = T_IM_BASE - 32'd4;
            4:       a = T_IM_BASE + ($urandom_range(0, 4095) * 32'd4) + 32'($urandom_range(1, 3));
            default: a = T_IM_BASE + ($urandom_range(0, 4095) * 32'd4);
        endcase
        return a;
    endfunction

    initial begin
        idle();
        m_pc = 32'hx;
        @(negedge clk);
        reset = 1'b1;
        cycle();
        chk("reset_addr", i_inst_addr, 32'h0000_3000);
        chk("reset_dpc", D_PC, 32'h0000_3000);
        reset = 1'b0;

        // Sequential fetch.
        cycle();
        chk("seq_3004", i_inst_addr, 32'h0000_3004);
        chk("seq_instr", D_Instr, im_word(32'h0000_3000));
        cycle();

        // Branch in D while F_PC=3008: slot 3008 becomes the delay slot.
        D_IsBranch = 1'b1; D_BranchTaken = 1'b1; D_BranchTarget = 32'h0000_3100;
        cycle();
        chk("br_target", i_inst_addr, 32'h0000_3100);
        chk("br_dpc", D_PC, 32'h0000_3008);
        chk("br_bd", {31'd0, D_BD}, 32'd1);
        idle();

        // Redirect to 3010 then stall two cycles.
        D_BranchTaken = 1'b1; D_BranchTarget = 32'h0000_3010;
        cycle();
        idle();
        F_Stall = 1'b1;
        cycle();
        cycle();
        chk("stall_hold", i_inst_addr, 32'h0000_3010);
        F_Stall = 1'b0;
        cycle();
        chk("stall_release", i_inst_addr, 32'h0000_3014);

        // Req during stall.
        F_Stall = 1'b1; Req = 1'b1;
        cycle();
        chk("req_pc", i_inst_addr, 32'h0000_4180);
        chk("req_dpc", D_PC, 32'h0000_4180);
        chk("req_instr", D_Instr, 32'd0);
        idle();

        // Eret held by stall, then released.
        D_Eret = 1'b1; EPC = 32'h0000_3024; F_Stall = 1'b1;
        cycle();
        chk("eret_stalled", i_inst_addr, 32'h0000_4180);
        F_Stall = 1'b0;
        cycle();
        chk("eret_pc", i_inst_addr, 32'h0000_3024);
        chk("eret_dpc", D_PC, 32'h0000_3024);
        chk("eret_instr", D_Instr, 32'd0);
        idle();

        // Misaligned and out-of-range redirects.
        D_BranchTaken = 1'b1; D_BranchTarget = 32'h0000_3002;
        cycle();
        D_BranchTarget = 32'h0000_7000;
        cycle();
        idle();
`ifdef ADEL_CHECK_EN
        chk("adel_mis_exc", {27'd0, D_ExcCode}, 32'd4);
        chk("adel_mis_instr", D_Instr, 32'd0);
`else
        chk("noadel_mis_exc", {27'd0, D_ExcCode}, 32'd0);
        chk("noadel_mis_instr", D_Instr, im_word(32'h0000_3002));
`endif
        cycle();
`ifdef ADEL_CHECK_EN
        chk("adel_top_exc", {27'd0, D_ExcCode}, 32'd4);
`else
        chk("noadel_top_exc", {27'd0, D_ExcCode}, 32'd0);
`endif

        // Random control traffic.
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            Req            = ($urandom_range(0, 19) == 0);
            F_Stall        = ($urandom_range(0, 4) == 0);
            D_Eret         = ($urandom_range(0, 11) == 0);
            D_IsBranch     = ($urandom_range(0, 3) == 0);
            D_BranchTaken  = D_IsBranch & $urandom_range(0, 1) == 1;
            D_BranchTarget = pick_addr();
            EPC            = pick_addr();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
